aes_shiftrows_stream: RTL and testbench
=======================================

Name: aes_shiftrows_stream

Overview:
Byte-serial Rijndael ShiftRows/InvShiftRows unit with a parametrised block width and valid/ready handshakes on both sides. It sits in the byte-wide round datapath between SubBytes and MixColumns. A two-bank ping-pong buffer sustains one byte per cycle with back-to-back blocks. The direction is selectable per block.

Parameters:
NB, 4, number of state columns; legal values are 4, 6 and 8. Block size is 4*NB bytes.
DATA_W, 8, symbol width in bits.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  in_data/in_mode are valid this cycle.
in_ready  output  1  unit can accept a byte this cycle.
in_data  input  DATA_W  input byte, column-major order (index = row + 4*col).
in_mode  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled on the first byte of each block.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  DATA_W  output byte, column-major order.
out_last  output  1  high with the final byte (index 4*NB-1) of a block.
out_mode  output  1  mode latched for the block currently being output.

Behaviour:
- Single clock domain; rst is synchronous and active-high.
- Reset state: both banks empty, write and read pointers at 0, bank select at bank 0, out_valid=0, out_last=0, out_mode=0, out_data=0, in_ready=1 on the first cycle after reset.
- Reset mid-block discards all partial and full blocks. No byte is output afterwards from a block accepted before reset.
- Input acceptance:
  - A byte is accepted when in_valid && in_ready.
  - It is written to the write bank at address wr_ptr, and wr_ptr increments.
  - On the first byte of a block (wr_ptr=0), in_mode is stored as that bank's mode.
  - When byte 4*NB-1 is accepted: the bank is marked full, wr_ptr wraps to 0, and the write bank toggles.
- in_ready = write bank not full. It is combinational from state only, never from in_valid.
- Output side:
  - out_valid = read bank full.
  - Output index k selects column c = k/4, row r = k%4.
  - ShiftRows: out(r,c) = in(r, (c+s(r)) mod NB).
  - InvShiftRows: out(r,c) = in(r, (c-s(r)) mod NB), computed without negative intermediates.
  - Shift offsets s(r):
    - NB=4: 0,1,2,3.
    - NB=6: 0,1,2,3.
    - NB=8: 0,1,3,4.
- Output transfer: when out_valid && out_ready, rd_ptr increments. On the transfer at index 4*NB-1: the bank is cleared, rd_ptr wraps to 0, and the read bank toggles.
- When out_valid=0, out_data, out_last and out_mode are forced to 0.
- Backpressure: while out_valid && !out_ready, out_data, out_last and out_mode hold stable.
- Latency: if the last input byte of a block is accepted in cycle t, out_valid=1 with output byte 0 in cycle t+1.
- Throughput: with out_ready held at 1 and in_valid held at 1, in_ready never drops. Output streams continuously at 1 byte/cycle after an initial 4*NB-cycle fill.
- Simultaneous events:
  - The last input byte filling bank A and the last output byte draining bank B in the same cycle are both honoured in that cycle.
  - When both banks are full, in_ready=0 until the read bank is cleared. in_ready returns to 1 in the cycle after the final out_valid && out_ready transfer.
- Modes of consecutive blocks are independent. A mode change on the first byte of the next block does not affect the block being output.
- Pointer widths are clog2(4*NB). Pointers never exceed 4*NB-1.
- NB outside {4,6,8} is a configuration error and is caught by an elaboration-time check.

Test Plan:
- NB=4, mode 0, in 00..0F, out_ready=1 -> out 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. out_valid first rises the cycle after byte 0F is accepted. out_last is high on 0b.
- NB=4, mode 1, in 00..0F -> out 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03. out_mode=1 throughout.
- NB=4, mode 0, FIPS-197 state d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> out d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
- NB=8, mode 0, in 00..1F -> first column out 00 05 0e 13. Applying mode 1 to that result restores 00..1F.
- NB=4, three back-to-back blocks with alternating modes, out_ready toggling 1/0 each cycle -> correct per-block permutation and mode. Data is held during stalls. in_ready drops only while both banks are full.
- NB=4, rst asserted after 9 bytes of block 2 while block 1 is half output -> out_valid=0 and in_ready=1 in the next cycle. A fresh block 00..0F then yields the exact first-scenario sequence.

Source files
------------

// File: rtl/aes_shiftrows_stream.sv
// -----------------------------------------------------------------------------
// aes_shiftrows_stream
//
// Byte-serial Rijndael ShiftRows / InvShiftRows unit for the byte-wide round
// datapath (between SubBytes and MixColumns). A block of 4*NB bytes arrives in
// column-major order (index = row + 4*col). It is captured into one bank of a
// two-bank ping-pong buffer. The permuted block is then read out of the other
// bank, so back-to-back blocks stream at one byte per cycle. The direction is
// chosen per block by the mode presented with the block's first byte.
//
// Parameters:
//   NB      number of state columns (4, 6 or 8); block size is 4*NB bytes
//   DATA_W  symbol width in bits
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   in_data / in_mode valid this cycle
//   in_ready   unit can accept a byte (depends on state only)
//   in_data    input byte, column-major order
//   in_mode    0 = ShiftRows, 1 = InvShiftRows (taken from first byte of block)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   output byte, column-major order
//   out_last   high with the final byte of a block
//   out_mode   mode of the block currently being output
// -----------------------------------------------------------------------------
module aes_shiftrows_stream #(
   parameter int NB     = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_mode
);

   localparam int BLK = 4 * NB;
   localparam int PW  = $clog2(BLK);
   localparam logic [PW-1:0] LAST_IDX = PW'(BLK - 1);

   // Only the Rijndael block sizes with a defined shift table are supported.
   if (NB != 4 && NB != 6 && NB != 8) begin : g_nb_check
      $error("aes_shiftrows_stream: NB must be 4, 6 or 8");
   end

   // Two banks of block storage plus per-bank full flag and latched mode.
   logic [DATA_W-1:0] bank_mem [2][BLK];
   logic [1:0]        bank_full;
   logic [1:0]        bank_mode;
   logic              wr_bank;
   logic              rd_bank;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic              accept;
   logic              drain;
   logic [PW-1:0]     src_idx;

   // Row shift offsets; the wider NB=8 state skips offset 2 on the lower rows.
   function automatic int shift_of(input int r);
      if (NB == 8 && r >= 2) begin
         return r + 1;
      end
      return r;
   endfunction

   // Handshake qualifiers. in_ready looks only at the write bank's state, so
   // it never combinationally depends on in_valid.
   assign in_ready  = !bank_full[wr_bank];
   assign out_valid = bank_full[rd_bank];
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // Pointer, bank-select and full/mode bookkeeping. A fill of one bank and
   // the drain of the other can complete in the same cycle; they touch
   // different bank_full bits, so both take effect together. The two can never
   // hit the same bank because writing needs it empty and reading needs it full.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_full <= '0;
         bank_mode <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         if (accept) begin
            if (wr_ptr == '0) begin
               bank_mode[wr_bank] <= in_mode;
            end
            if (wr_ptr == LAST_IDX) begin
               wr_ptr             <= '0;
               bank_full[wr_bank] <= 1'b1;
               wr_bank            <= ~wr_bank;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
         if (drain) begin
            if (rd_ptr == LAST_IDX) begin
               rd_ptr             <= '0;
               bank_full[rd_bank] <= 1'b0;
               rd_bank            <= ~rd_bank;
            end else begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end
   end

   // Block storage. It has no reset: a bank's contents are only ever observed
   // while its full flag is set, and reset clears every full flag.
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         bank_mem[wr_bank][wr_ptr] <= in_data;
      end
   end

   // Map the output index to the input byte that lands there. The inverse
   // direction adds NB before subtracting the shift so the column never goes
   // negative; one conditional subtract then brings it back into 0..NB-1.
   always_comb begin
      int row;
      int col;
      int sh;
      int src_col;
      row     = int'(rd_ptr[1:0]);
      col     = int'(rd_ptr[PW-1:2]);
      sh      = shift_of(row);
      src_col = 0;
      if (!bank_mode[rd_bank]) begin
         src_col = col + sh;
      end else begin
         src_col = col + NB - sh;
      end
      if (src_col >= NB) begin
         src_col = src_col - NB;
      end
      src_idx = PW'(row + 4 * src_col);
   end

   // Output side. Everything is derived from registered state, so the values
   // hold still while the consumer stalls, and they are forced to zero when no
   // block is ready.
   always_comb begin
      out_data = '0;
      out_last = 1'b0;
      out_mode = 1'b0;
      if (out_valid) begin
         out_data = bank_mem[rd_bank][src_idx];
         out_last = (rd_ptr == LAST_IDX);
         out_mode = bank_mode[rd_bank];
      end
   end

endmodule

// File: tb/tb_aes_shiftrows_stream.sv
// -----------------------------------------------------------------------------
// tb_aes_shiftrows_stream
//
// Scoreboard bench for aes_shiftrows_stream. One instance uses NB=4 and a
// second uses NB=8. Expected output bytes are queued when a block is driven and
// are consumed as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_aes_shiftrows_stream;

   typedef logic [7:0] blk_t [32];
   typedef struct packed {
      logic [7:0] d;
      logic       last;
      logic       mode;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   logic       in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_last4, out_mode4;
   logic [7:0] in_data4, out_data4;
   logic       in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_last8, out_mode8;
   logic [7:0] in_data8, out_data8;

   exp_t q4[$];
   exp_t q8[$];
   int   vectors     = 0;
   int   miscompares = 0;
   bit   toggle_ready = 1'b0;

   always #5 clk = ~clk;

   aes_shiftrows_stream #(.NB(4), .DATA_W(8)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .out_last(out_last4), .out_mode(out_mode4)
   );

   aes_shiftrows_stream #(.NB(8), .DATA_W(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .out_last(out_last8), .out_mode(out_mode8)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference permutation: lay the block out as a 4 x nb state and physically
   // rotate each row one step at a time by its offset.
   function automatic blk_t modelShift(input int nb, input blk_t d, input logic mode);
      logic [7:0] st [4][8];
      logic [7:0] tmp;
      blk_t       res;
      int         sh4 [4] = '{0, 1, 2, 3};
      int         sh8 [4] = '{0, 1, 3, 4};
      int         s;
      foreach (res[i]) res[i] = 8'h00;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            st[r][c] = (c < nb) ? d[r + 4 * c] : 8'h00;
      for (int r = 0; r < 4; r++) begin
         s = (nb == 8) ? sh8[r] : sh4[r];
         for (int n = 0; n < s; n++) begin
            if (!mode) begin
               tmp = st[r][0];
               for (int c = 0; c < nb - 1; c++) st[r][c] = st[r][c + 1];
               st[r][nb - 1] = tmp;
            end else begin
               tmp = st[r][nb - 1];
               for (int c = nb - 1; c > 0; c--) st[r][c] = st[r][c - 1];
               st[r][0] = tmp;
            end
         end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < nb; c++)
            res[r + 4 * c] = st[r][c];
      return res;
   endfunction

   function automatic blk_t fromHex16(input logic [127:0] h);
      blk_t r;
      foreach (r[i]) r[i] = 8'h00;
      for (int i = 0; i < 16; i++) r[i] = h[127 - 8 * i -: 8];
      return r;
   endfunction

   function automatic blk_t ramp(input int n);
      blk_t r;
      foreach (r[i]) r[i] = (i < n) ? 8'(i) : 8'h00;
      return r;
   endfunction

   // Drive nbytes of a block. For a full block the expected output is queued
   // first. in_mode is inverted after the first byte, because only the first
   // byte's mode may count.
   task automatic applyStimulus(input int nb, input blk_t d, input logic mode,
                                input blk_t e, input int nbytes);
      int blk;
      bit rdy;
      int waitc;
      blk = 4 * nb;
      if (nbytes == blk) begin
         for (int k = 0; k < blk; k++) begin
            if (nb == 8) q8.push_back(exp_t'{d: e[k], last: (k == blk - 1), mode: mode});
            else         q4.push_back(exp_t'{d: e[k], last: (k == blk - 1), mode: mode});
         end
      end
      for (int k = 0; k < nbytes; k++) begin
         if (nb == 8) begin
            in_valid8 = 1'b1; in_data8 = d[k]; in_mode8 = (k == 0) ? mode : ~mode;
         end else begin
            in_valid4 = 1'b1; in_data4 = d[k]; in_mode4 = (k == 0) ? mode : ~mode;
         end
         waitc = 0;
         do begin
            @(negedge clk);
            rdy = (nb == 8) ? in_ready8 : in_ready4;
            @(posedge clk);
            #1;
            waitc++;
         end while (!rdy && waitc < 200);
         if (!rdy) checkOutput("in_ready_timeout", 32'd0, 32'd1);
      end
      if (nb == 8) in_valid8 = 1'b0;
      else         in_valid4 = 1'b0;
   endtask

   // Wait until every queued expected byte has been produced, bounded.
   task automatic waitDrain(input int nb);
      int n;
      n = 0;
      while (((nb == 8) ? q8.size() : q4.size()) != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      if (((nb == 8) ? q8.size() : q4.size()) != 0)
         checkOutput("drain_timeout", (nb == 8) ? q8.size() : q4.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor for the NB=4 instance, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid4) begin
            if (q4.size() == 0) begin
               checkOutput("unexpected_out4", {24'd0, out_data4}, 32'hffff_ffff);
            end else begin
               e = q4[0];
               checkOutput("data4", {24'd0, out_data4}, {24'd0, e.d});
               checkOutput("last4", {31'd0, out_last4}, {31'd0, e.last});
               checkOutput("mode4", {31'd0, out_mode4}, {31'd0, e.mode});
               if (out_ready4) void'(q4.pop_front());
            end
         end else begin
            checkOutput("idle_outputs4", {22'd0, out_data4, out_last4, out_mode4}, 32'd0);
         end
         if (!in_ready4) checkOutput("in_ready4_only_when_both_full", {31'd0, out_valid4}, 32'd1);
      end
   end

   // Monitor for the NB=8 instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid8) begin
            if (q8.size() == 0) begin
               checkOutput("unexpected_out8", {24'd0, out_data8}, 32'hffff_ffff);
            end else begin
               e = q8[0];
               checkOutput("data8", {24'd0, out_data8}, {24'd0, e.d});
               checkOutput("last8", {31'd0, out_last8}, {31'd0, e.last});
               checkOutput("mode8", {31'd0, out_mode8}, {31'd0, e.mode});
               if (out_ready8) void'(q8.pop_front());
            end
         end else begin
            checkOutput("idle_outputs8", {22'd0, out_data8, out_last8, out_mode8}, 32'd0);
         end
      end
   end

   // Optional consumer stall pattern: out_ready alternates every cycle.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (toggle_ready) out_ready4 = ~out_ready4;
      end
   end

   // Global bound on run length.
   initial begin
      repeat (50000) @(posedge clk);
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      blk_t exp1, exp2, fin, fout, a, e, b, dummy;
      exp1  = fromHex16(128'h00050a0f04090e03080d02070c01060b);
      exp2  = fromHex16(128'h000d0a0704010e0b0805020f0c090603);
      fin   = fromHex16(128'hd42711aee0bf98f1b8b45de51e415230);
      fout  = fromHex16(128'hd4bf5d30e0b452aeb84111f11e2798e5);
      foreach (dummy[i]) dummy[i] = 8'h00;

      rst = 1'b1;
      in_valid4 = 1'b0; in_data4 = 8'h00; in_mode4 = 1'b0; out_ready4 = 1'b1;
      in_valid8 = 1'b0; in_data8 = 8'h00; in_mode8 = 1'b0; out_ready8 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset_out_valid", {31'd0, out_valid4}, 32'd0);
      checkOutput("reset_in_ready", {31'd0, in_ready4}, 32'd1);
      checkOutput("reset_outputs", {22'd0, out_data4, out_last4, out_mode4}, 32'd0);
      checkOutput("reset_in_ready8", {31'd0, in_ready8}, 32'd1);

      $display("[TB] NB=4 ShiftRows ramp");
      applyStimulus(4, ramp(16), 1'b0, exp1, 16);
      checkOutput("latency_out_valid", {31'd0, out_valid4}, 32'd1);
      waitDrain(4);

      $display("[TB] NB=4 InvShiftRows ramp");
      applyStimulus(4, ramp(16), 1'b1, exp2, 16);
      waitDrain(4);

      $display("[TB] NB=4 FIPS-197 state");
      applyStimulus(4, fin, 1'b0, fout, 16);
      waitDrain(4);

      $display("[TB] NB=8 forward then inverse");
      a = ramp(32);
      e = modelShift(8, a, 1'b0);
      b = e;
      e[0] = 8'h00; e[1] = 8'h05; e[2] = 8'h0e; e[3] = 8'h13;
      applyStimulus(8, a, 1'b0, e, 32);
      applyStimulus(8, b, 1'b1, a, 32);
      waitDrain(8);

      $display("[TB] NB=4 back-to-back with stalls");
      toggle_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         foreach (a[i]) a[i] = (i < 16) ? 8'($urandom_range(0, 255)) : 8'h00;
         applyStimulus(4, a, 1'(n % 2), modelShift(4, a, 1'(n % 2)), 16);
      end
      waitDrain(4);
      toggle_ready = 1'b0;
      out_ready4 = 1'b1;

      $display("[TB] NB=4 reset mid-stream");
      foreach (a[i]) a[i] = (i < 16) ? 8'(8'h40 + i) : 8'h00;
      applyStimulus(4, a, 1'b0, modelShift(4, a, 1'b0), 16);
      foreach (b[i]) b[i] = (i < 16) ? 8'(8'h80 + i) : 8'h00;
      applyStimulus(4, b, 1'b1, dummy, 9);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q4.delete();
      checkOutput("post_reset_out_valid", {31'd0, out_valid4}, 32'd0);
      checkOutput("post_reset_in_ready", {31'd0, in_ready4}, 32'd1);
      applyStimulus(4, ramp(16), 1'b0, exp1, 16);
      waitDrain(4);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
